// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub_pkg
// Purpose : Shared definitions for the bit-serial subtractor: FSM state
//           encoding used by the serial_sub top level.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

  // IDLE accepts work, RUN streams one bit per cycle, DONE is the pulse cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_fs_cell.sv
`default_nettype none
// ============================================================================
// Module  : fs_cell
// Purpose : One-bit full subtractor, purely combinational. Computes
//           a - b - bi, giving the difference bit and the borrow out.
// Ports   : a  - minuend bit
//           b  - subtrahend bit
//           bi - borrow in
//           d  - difference bit
//           bo - borrow out
// Rev     : 1.0  initial release
// ============================================================================
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when a<b outright, or a==b and a borrow is already pending.
  assign bo = (~(a ^ b) & bi) | (~a & b);

endmodule : fs_cell
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub
// Purpose : Bit-serial WIDTH-bit unsigned subtractor. Operands are captured
//           on a start/ready handshake, then one bit pair per clock (LSB
//           first) passes through a single fs_cell. After WIDTH bit-cycles
//           the difference and final borrow are registered and flagged with
//           a one-cycle done pulse.
// Ports   : clk    - rising-edge clock
//           rst_n  - synchronous active-low reset
//           start  - request, accepted when ready=1
//           a_in   - minuend, sampled at acceptance
//           b_in   - subtrahend, sampled at acceptance
//           bin_in - initial borrow, sampled at acceptance
//           ready  - high while idle
//           done   - one-cycle pulse when diff/bout are newly valid
//           diff   - (a - b - bin) mod 2^WIDTH, registered
//           bout   - final borrow, registered
// Rev     : 1.0  initial release
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  // Holds the WIDTH-1 result bits gathered so far; the final bit comes
  // straight from the cell on the exit edge.
  logic [WIDTH-2:0]   res_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               done_q;

  logic               cell_d;
  logic               cell_bo;
  logic [WIDTH-1:0]   res_d;

  fs_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result image after this bit: new bit enters at the MSB, older bits
  // move toward the LSB, so after WIDTH shifts bit 0 sits at the bottom.
  assign res_d = {cell_d, res_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q   <= a_in;
            b_sr_q   <= b_in;
            borrow_q <= bin_in;
            res_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end

        RUN: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          borrow_q <= cell_bo;
          res_q    <= res_d[WIDTH-1:1];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            diff_q  <= res_d;
            bout_q  <= cell_bo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule : serial_sub
`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit unsigned subtractor. It accepts two WIDTH-bit operands and a borrow-in via a start/ready handshake, then feeds one bit pair per clock, LSB first, through a single one-bit full-subtractor cell. A borrow flop carries the borrow between bits. After WIDTH bit-cycles it presents the WIDTH-bit difference and the final borrow with a one-cycle done pulse. It is the multi-bit datapath stage built directly around the team's one-bit full-subtractor cell, trading latency for area.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH ≥ 2.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low. Sampled on the clk rising edge.
- start  in  1  request; accepted only on an edge where ready=1.
- a_in  in  WIDTH  minuend; sampled only at acceptance.
- b_in  in  WIDTH  subtrahend; sampled only at acceptance.
- bin_in  in  1  initial borrow-in; sampled only at acceptance.
- ready  out  1  high when state is IDLE; combinational from state.
- done  out  1  one-cycle pulse; marks diff/bout as newly valid.
- diff  out  WIDTH  result, (a_in − b_in − bin_in) mod 2^WIDTH; registered.
- bout  out  1  final borrow; 1 iff a_in < b_in + bin_in (unsigned); registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1.
  - start=1 at an edge → capture a_in, b_in, bin_in into shift registers a_sr, b_sr and the borrow flop; clear the bit counter; go to RUN.
  - start=0 → stay in IDLE.
- RUN: ready=0; start is ignored; a_in, b_in and bin_in are don't-care. Each edge does the following:
  - cell inputs are a_sr[0], b_sr[0] and the borrow flop;
  - the cell D output shifts into the MSB of the result shift register;
  - a_sr and b_sr shift right by one;
  - the borrow flop takes the cell Bo output;
  - the counter increments.
- RUN exit: on the edge where counter = WIDTH−1, load diff with the final result image and bout with that bit's Bo, set done=1, and go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle; the next edge clears done and returns to IDLE.
- diff and bout hold their values until the next RUN exit; they do not change during a following RUN.
- Cell equations: D = a ^ b ^ bi; Bo = (~(a ^ b) & bi) | (~a & b).
- Reset (rst_n=0 at an edge, in any state):
  - state → IDLE; diff, bout, done, shift registers, borrow flop and counter → 0; ready=1 in the following cycle.
  - A reset during RUN aborts the operation; no done pulse is produced.
- Boundaries:
  - a=b with bin=1 → all-ones diff, bout=1.
  - a=0 with b=0 and bin=0 → diff 0, bout 0.
  - A start pulse during RUN or DONE is dropped, not queued.

## Timing
- Acceptance edge E0, where start=1 and ready=1.
- Bit i is processed at edge E(i+1).
- diff, bout and done update at edge E(WIDTH); done is high for the cycle between E(WIDTH) and E(WIDTH+1).
- ready returns high after E(WIDTH+1). The earliest next acceptance is E(WIDTH+2), giving a throughput of one operation per WIDTH+2 cycles.
- Combinational path: the cell plus the result-shift mux only. No path exists from any input port to any output port.

## Structure
- Package serial_sub_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Counter width is local, $clog2(WIDTH).
- Sub-module fs_cell: purely combinational one-bit full subtractor (a, b, bi → d, bo), instantiated once.
- Top module: FSM, counter, a_sr/b_sr/result shift registers, borrow flop, output registers.

## Test plan
All scenarios use WIDTH=8.
- Basic: a=0x5A, b=0x23, bin=0, accepted at E0 → done high only after E8, diff=0x37, bout=0; ready low from E0 until E9.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
- Borrow-in on equal operands: a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1. Also a=0xFF, b=0x00, bin=1 → diff=0xFE, bout=0.
- Handshake integrity:
  - start held high continuously → accepted operations every 10 cycles;
  - changing a_in/b_in/bin_in during RUN does not alter the result;
  - diff is stable between done pulses.
- Reset mid-RUN: rst_n=0 at E4 → no done, diff=0, bout=0, ready=1 next cycle; the next operation a=0x80, b=0x7F, bin=0 gives diff=0x01, bout=0.
- Sweep: run WIDTH=4 exhaustively over all a, b and bin (512 cases), comparing {bout, diff} to (a − b − bin) mod 32 with bout = (a < b + bin).
